mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported memory between instruction fetch (IF) and the load/store path (D).
//   D requests come from the decoder's mem_read/mem_write strobes.
//   Serialises accesses through a 3-state FSM, prioritises data, bounds IF starvation, supports IF flush.
//   Also runs a timeout watchdog. Sits between the pipeline front/back ends and the memory wrapper.
// PARAMETERS
//   ADDR_W        32   address width
//   DATA_W        32   data width; byte-enable width is DATA_W/8
//   STARVE_LIMIT  4    consecutive D wins over a pending IF before IF is forced (>=1)
//   TIMEOUT       16   BUSY cycles without mem_ready_i before abort (>=2)
// PORTS
//   clk_i         in   1          clock, rising edge
//   rst_i         in   1          synchronous reset, active-high
//   if_req_i      in   1          fetch request; held until if_gnt_o
//   if_addr_i     in   ADDR_W     fetch address
//   if_flush_i    in   1          discard result of in-flight fetch (branch/jump taken)
//   if_gnt_o      out  1          fetch accepted this cycle
//   if_valid_o    out  1          fetch data valid (1-cycle pulse)
//   if_rdata_o    out  DATA_W     fetch data
//   d_req_i       in   1          data request; held until d_gnt_o
//   d_we_i        in   1          1 = store, 0 = load
//   d_addr_i      in   ADDR_W     data address
//   d_wdata_i     in   DATA_W     store data
//   d_be_i        in   DATA_W/8   byte enables
//   d_gnt_o       out  1          data request accepted this cycle
//   d_valid_o     out  1          data access complete (1-cycle pulse; loads and stores)
//   d_rdata_o     out  DATA_W     load data (0 for stores)
//   mem_req_o     out  1          memory request
//   mem_we_o      out  1          memory write enable
//   mem_addr_o    out  ADDR_W     memory address
//   mem_wdata_o   out  DATA_W     memory write data
//   mem_be_o      out  DATA_W/8   memory byte enables
//   mem_ready_i   in   1          memory done; read data valid on mem_rdata_i
//   mem_rdata_i   in   DATA_W     memory read data
//   err_o         out  1          timeout abort (1-cycle pulse)
// BEHAVIOUR
//   Reset: state=IDLE. All outputs 0 the cycle after rst_i sampled high, including starve_cnt.
//     Reset mid-access abandons it: no valid/err pulse, mem_req_o drops.
//   FSM states and transitions:
//     IDLE -> BUSY_D on d_gnt_o.
//     IDLE -> BUSY_IF on if_gnt_o.
//     BUSY_x -> IDLE on mem_ready_i, or when the timeout counter reaches TIMEOUT.
//   Grant (combinational, only in IDLE, at most one per cycle):
//     d_gnt_o  = d_req_i & ~(if_req_i & starve_cnt==STARVE_LIMIT).
//     if_gnt_o = if_req_i & ~d_gnt_o.
//     On grant, addr/we/wdata/be are latched. Requests may change freely after grant.
//   starve_cnt:
//     +1 (saturating at STARVE_LIMIT) when D granted while if_req_i=1.
//     Cleared on if_gnt_o or when if_req_i=0 in IDLE.
//   BUSY_x: mem_req_o=1, driven from latched regs only.
//     IF accesses drive mem_we_o=0, mem_be_o=all ones.
//     mem_ready_i sampled high -> next cycle x_valid_o=1 and x_rdata_o=registered mem_rdata_i,
//     state=IDLE, mem_req_o=0.
//     Zero-wait access: grant cycle N, mem_req_o N+1, valid N+2.
//     A new grant is allowed in cycle N+2 (2-cycle minimum per access).
//   rdata outputs hold their value between valid pulses.
//   Timeout: counter cleared on entering BUSY, incremented each BUSY cycle without mem_ready_i.
//     At TIMEOUT: -> IDLE; next cycle err_o=1 and x_valid_o=1 with x_rdata_o=0.
//     mem_ready_i in the same cycle as the timeout is honoured as a normal completion; no err.
//   Flush:
//     if_flush_i in BUSY_IF, or in the grant cycle of an IF: sets a drop flag.
//     The transaction still completes on memory, but if_valid_o is suppressed and if_rdata_o is not updated.
//     Flush coinciding with mem_ready_i also suppresses.
//     Flush in IDLE without grant, or during BUSY_D: no effect.
//     A dropped IF timeout still raises err_o.
//   Stores: d_rdata_o=0 on completion. Simultaneous flush and D request: D is unaffected.
// TESTING
//   1. Reset: rst_i=1 with FSM in BUSY_D -> next cycle mem_req_o=0, d_valid_o=0, err_o=0.
//   2. Single load, mem_ready_i on first BUSY cycle, mem_rdata_i=32'hDEADBEEF
//      -> d_gnt_o cyc0, mem_req_o cyc1, d_valid_o cyc2 with d_rdata_o=32'hDEADBEEF.
//   3. if_req_i and d_req_i held high continuously, STARVE_LIMIT=4
//      -> grant order D,D,D,D,IF,D,D,D,D,IF...
//   4. IF access with mem_ready_i at BUSY cycle 3 and if_flush_i pulsed in BUSY cycle 1
//      -> no if_valid_o, if_rdata_o unchanged, next grant allowed after completion.
//   5. Store with mem_ready_i never asserted, TIMEOUT=16
//      -> 16 BUSY cycles, then err_o=1 and d_valid_o=1 with d_rdata_o=0, mem_req_o=0.
//   6. Store addr=32'h100, be=4'b0011, wdata=32'h1234
//      -> mem_we_o=1, mem_addr_o=32'h100, mem_be_o=4'b0011 held stable across BUSY;
//         d_valid_o pulse, d_rdata_o=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data has priority; a starvation counter forces a waiting fetch through.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                if_req_i,
   input  logic [ADDR_W-1:0]   if_addr_i,
   input  logic                if_flush_i,
   output logic                if_gnt_o,
   output logic                if_valid_o,
   output logic [DATA_W-1:0]   if_rdata_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [DATA_W-1:0]   d_wdata_i,
   input  logic [DATA_W/8-1:0] d_be_i,
   output logic                d_gnt_o,
   output logic                d_valid_o,
   output logic [DATA_W-1:0]   d_rdata_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [DATA_W-1:0]   mem_wdata_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   input  logic                mem_ready_i,
   input  logic [DATA_W-1:0]   mem_rdata_i,
   output logic                err_o
);

   localparam int BE_W = DATA_W / 8;
   localparam int SW   = $clog2(STARVE_LIMIT + 1);
   localparam int TW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY_D,
      S_BUSY_IF
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [SW-1:0]       r_starve;
   logic [TW-1:0]       r_tcnt;
   logic                r_drop;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [BE_W-1:0]     r_be;
   logic                r_d_valid;
   logic                r_if_valid;
   logic                r_err;
   logic [DATA_W-1:0]   r_d_rdata;
   logic [DATA_W-1:0]   r_if_rdata;

   logic w_idle;
   logic w_busy;
   logic w_d_gnt;
   logic w_if_gnt;
   logic w_tout;
   logic w_done;
   logic w_drop;

   assign w_idle   = (r_state == S_IDLE);
   assign w_busy   = ~w_idle;
   assign w_d_gnt  = w_idle & d_req_i
                   & ~(if_req_i & (r_starve == SW'(STARVE_LIMIT)));
   assign w_if_gnt = w_idle & if_req_i & ~w_d_gnt;
   // A completion in the same cycle as the last allowed wait wins over abort
   assign w_tout   = w_busy & ~mem_ready_i & (r_tcnt == TW'(TIMEOUT - 1));
   assign w_done   = w_busy & (mem_ready_i | w_tout);
   assign w_drop   = r_drop | ((r_state == S_BUSY_IF) & if_flush_i);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_d_gnt)
               w_next = S_BUSY_D;
            else if (w_if_gnt)
               w_next = S_BUSY_IF;
         end
         S_BUSY_D,
         S_BUSY_IF: begin
            if (w_done)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_starve <= '0;
         r_tcnt   <= '0;
         r_drop   <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= '0;
      end else if (w_idle) begin
         r_tcnt <= '0;
         r_drop <= w_if_gnt & if_flush_i;
         if (w_if_gnt | ~if_req_i)
            r_starve <= '0;
         else if (w_d_gnt && r_starve != SW'(STARVE_LIMIT))
            r_starve <= r_starve + SW'(1);
         if (w_d_gnt) begin
            r_we    <= d_we_i;
            r_addr  <= d_addr_i;
            r_wdata <= d_wdata_i;
            r_be    <= d_be_i;
         end else if (w_if_gnt) begin
            r_we    <= 1'b0;
            r_addr  <= if_addr_i;
            r_wdata <= '0;
            r_be    <= '1;
         end
      end else begin
         r_drop <= w_drop;
         if (!mem_ready_i)
            r_tcnt <= r_tcnt + TW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_d_valid  <= 1'b0;
         r_if_valid <= 1'b0;
         r_err      <= 1'b0;
         r_d_rdata  <= '0;
         r_if_rdata <= '0;
      end else begin
         r_d_valid  <= 1'b0;
         r_if_valid <= 1'b0;
         r_err      <= 1'b0;
         if (w_done) begin
            r_err <= w_tout;
            if (r_state == S_BUSY_D) begin
               r_d_valid <= 1'b1;
               r_d_rdata <= (w_tout | r_we) ? '0 : mem_rdata_i;
            end else if (!w_drop) begin
               r_if_valid <= 1'b1;
               r_if_rdata <= w_tout ? '0 : mem_rdata_i;
            end
         end
      end
   end

   assign d_gnt_o     = w_d_gnt;
   assign if_gnt_o    = w_if_gnt;
   assign mem_req_o   = w_busy;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign mem_be_o    = r_be;
   assign d_valid_o   = r_d_valid;
   assign d_rdata_o   = r_d_rdata;
   assign if_valid_o  = r_if_valid;
   assign if_rdata_o  = r_if_rdata;
   assign err_o       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences,
// then random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int SL  = 4;
   localparam int TMO = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_flush_i;
   logic        if_gnt_o;
   logic        if_valid_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [3:0]  d_be_i;
   logic        d_gnt_o;
   logic        d_valid_o;
   logic [31:0] d_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_be_o;
   logic        mem_ready_i;
   logic [31:0] mem_rdata_i;
   logic        err_o;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TMO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i),
      .if_flush_i(if_flush_i), .if_gnt_o(if_gnt_o),
      .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
      .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
      .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_gnt_o(d_gnt_o),
      .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_be_o(mem_be_o), .mem_ready_i(mem_ready_i),
      .mem_rdata_i(mem_rdata_i), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          dreq;
      bit          dwe;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dbe;
      bit          ireq;
      logic [31:0] iaddr;
      bit          fl;
      bit          rdy;
      logic [31:0] rdata;
      bit          edg;
      bit          eig;
      bit          emreq;
      bit          emwe;
      logic [31:0] emaddr;
      logic [3:0]  embe;
      bit          edv;
      bit          eiv;
      logic [31:0] edrd;
      logic [31:0] eird;
   } vec_t;

   int n_pass = 0;
   int n_tot  = 0;

   // transaction-level reference state
   bit          m_busy, m_own_if, m_we, m_drop;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_be;
   int          m_wait, m_starve;
   bit          e_dv, e_iv, e_err;
   logic [31:0] e_drd, e_ird;
   bit          g_d, g_if;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic model_reset();
      m_busy = 0; m_own_if = 0; m_we = 0; m_drop = 0;
      m_addr = 0; m_wdata = 0; m_be = 0; m_wait = 0; m_starve = 0;
      e_dv = 0; e_iv = 0; e_err = 0; e_drd = 0; e_ird = 0;
   endtask

   task automatic step(input bit has_row, input vec_t r);
      bit edg, eig, drop_now, tout;
      #2;
      edg = !m_busy && d_req_i && !(if_req_i && m_starve == SL);
      eig = !m_busy && if_req_i && !edg;
      chk("d_gnt", d_gnt_o, edg);
      chk("if_gnt", if_gnt_o, eig);
      chk("mem_req", mem_req_o, m_busy);
      if (m_busy) begin
         chk("mem_we", mem_we_o, m_we);
         chk("mem_addr", mem_addr_o, m_addr);
         chk("mem_be", mem_be_o, m_be);
         if (!m_own_if) chk("mem_wdata", mem_wdata_o, m_wdata);
      end
      chk("d_valid", d_valid_o, e_dv);
      chk("if_valid", if_valid_o, e_iv);
      chk("err", err_o, e_err);
      chk("d_rdata", d_rdata_o, e_drd);
      chk("if_rdata", if_rdata_o, e_ird);
      if (has_row) begin
         chk("tbl_d_gnt", d_gnt_o, r.edg);
         chk("tbl_if_gnt", if_gnt_o, r.eig);
         chk("tbl_mem_req", mem_req_o, r.emreq);
         if (r.emreq) begin
            chk("tbl_mem_we", mem_we_o, r.emwe);
            chk("tbl_mem_addr", mem_addr_o, r.emaddr);
            chk("tbl_mem_be", mem_be_o, r.embe);
         end
         chk("tbl_d_valid", d_valid_o, r.edv);
         chk("tbl_if_valid", if_valid_o, r.eiv);
         chk("tbl_d_rdata", d_rdata_o, r.edrd);
         chk("tbl_if_rdata", if_rdata_o, r.eird);
      end
      g_d = edg;
      g_if = eig;
      e_dv = 0; e_iv = 0; e_err = 0;
      if (rst_i) begin
         model_reset();
      end else if (m_busy) begin
         drop_now = m_drop || (m_own_if && if_flush_i);
         tout = 0;
         if (!mem_ready_i) begin
            m_wait++;
            tout = (m_wait == TMO);
         end
         if (mem_ready_i || tout) begin
            m_busy = 0;
            e_err = tout;
            if (!m_own_if) begin
               e_dv = 1;
               e_drd = (tout || m_we) ? 32'h0 : mem_rdata_i;
            end else if (!drop_now) begin
               e_iv = 1;
               e_ird = tout ? 32'h0 : mem_rdata_i;
            end
         end else begin
            m_drop = drop_now;
         end
      end else begin
         if (eig || !if_req_i) m_starve = 0;
         else if (edg && m_starve < SL) m_starve++;
         if (edg) begin
            m_busy = 1; m_own_if = 0; m_we = d_we_i;
            m_addr = d_addr_i; m_wdata = d_wdata_i; m_be = d_be_i;
            m_wait = 0; m_drop = 0;
         end else if (eig) begin
            m_busy = 1; m_own_if = 1; m_we = 0;
            m_addr = if_addr_i; m_be = 4'hF;
            m_wait = 0; m_drop = if_flush_i;
         end
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      d_req_i = 0; d_we_i = 0; d_addr_i = 0; d_wdata_i = 0; d_be_i = 0;
      if_req_i = 0; if_addr_i = 0; if_flush_i = 0;
      mem_ready_i = 0; mem_rdata_i = 0;
   endtask

   vec_t tbl[15];
   vec_t vnone;

   initial begin
      string gseq;
      string gexp;
      int    ntmo;
      int    pct;
      vnone = tbl[0];
      tbl[0]  = '{1,0,'h40,0,'hF, 0,0,0,0,0, 1,0,0,0,0,0, 0,0,0,0};
      tbl[1]  = '{0,0,0,0,0, 0,0,0,1,'hDEADBEEF,
                  0,0,1,0,'h40,'hF, 0,0,0,0};
      tbl[2]  = '{0,0,0,0,0, 0,0,0,0,0,
                  0,0,0,0,0,0, 1,0,'hDEADBEEF,0};
      tbl[3]  = '{1,1,'h100,'h1234,'h3, 0,0,0,0,0,
                  1,0,0,0,0,0, 0,0,'hDEADBEEF,0};
      tbl[4]  = '{0,0,0,0,0, 0,0,0,0,0,
                  0,0,1,1,'h100,'h3, 0,0,'hDEADBEEF,0};
      tbl[5]  = tbl[4];
      tbl[6]  = '{0,0,0,0,0, 0,0,0,1,'h9999,
                  0,0,1,1,'h100,'h3, 0,0,'hDEADBEEF,0};
      tbl[7]  = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 1,0,0,0};
      tbl[8]  = '{0,0,0,0,0, 1,'h200,0,0,0, 0,1,0,0,0,0, 0,0,0,0};
      tbl[9]  = '{0,0,0,0,0, 0,0,1,0,0, 0,0,1,0,'h200,'hF, 0,0,0,0};
      tbl[10] = '{0,0,0,0,0, 0,0,0,0,0, 0,0,1,0,'h200,'hF, 0,0,0,0};
      tbl[11] = '{0,0,0,0,0, 0,0,0,1,'h5555,
                  0,0,1,0,'h200,'hF, 0,0,0,0};
      tbl[12] = '{0,0,0,0,0, 1,'h204,0,0,0, 0,1,0,0,0,0, 0,0,0,0};
      tbl[13] = '{0,0,0,0,0, 0,0,0,1,'hCAFEF00D,
                  0,0,1,0,'h204,'hF, 0,0,0,0};
      tbl[14] = '{0,0,0,0,0, 0,0,0,0,0,
                  0,0,0,0,0,0, 0,1,0,'hCAFEF00D};

      idle_inputs();
      rst_i = 1;
      repeat (2) @(posedge clk_i);
      #1;
      model_reset();
      step(0, vnone);
      rst_i = 0;

      for (int i = 0; i < 15; i++) begin
         d_req_i = tbl[i].dreq; d_we_i = tbl[i].dwe;
         d_addr_i = tbl[i].daddr; d_wdata_i = tbl[i].dwdata;
         d_be_i = tbl[i].dbe; if_req_i = tbl[i].ireq;
         if_addr_i = tbl[i].iaddr; if_flush_i = tbl[i].fl;
         mem_ready_i = tbl[i].rdy; mem_rdata_i = tbl[i].rdata;
         step(1, tbl[i]);
      end

      // both requesters saturated: fetch forced in after four data wins
      idle_inputs();
      d_req_i = 1; if_req_i = 1; mem_ready_i = 1;
      d_addr_i = 32'h500; if_addr_i = 32'h600;
      gseq = "";
      for (int c = 0; c < 30 && gseq.len() < 10; c++) begin
         step(0, vnone);
         if (g_d) gseq = {gseq, "D"};
         if (g_if) gseq = {gseq, "I"};
      end
      gexp = "DDDDIDDDDI";
      n_tot++;
      if (gseq == gexp) n_pass++;
      else $display("FAIL grant_order: got %s expected %s", gseq, gexp);

      // reset while a load is in flight
      idle_inputs();
      mem_ready_i = 1;
      repeat (2) step(0, vnone);
      mem_ready_i = 0;
      d_req_i = 1; d_addr_i = 32'h44;
      step(0, vnone);
      d_req_i = 0;
      step(0, vnone);
      rst_i = 1;
      mem_ready_i = 1;
      mem_rdata_i = 32'h77;
      step(0, vnone);
      rst_i = 0;
      mem_ready_i = 0;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_d_valid", d_valid_o, 0);
      chk("rst_err", err_o, 0);
      step(0, vnone);

      // store never acknowledged
      d_req_i = 1; d_we_i = 1; d_addr_i = 32'h300;
      d_wdata_i = 32'hAA55; d_be_i = 4'hF;
      step(0, vnone);
      d_req_i = 0;
      ntmo = 0;
      while (mem_req_o && ntmo < 40) begin
         ntmo++;
         step(0, vnone);
      end
      chk("tmo_busy_cycles", ntmo, TMO);
      chk("tmo_err", err_o, 1);
      chk("tmo_d_valid", d_valid_o, 1);
      chk("tmo_d_rdata", d_rdata_o, 0);
      chk("tmo_mem_req", mem_req_o, 0);

      // random traffic
      g_d = 0; g_if = 0;
      pct = 50;
      for (int c = 0; c < 4000; c++) begin
         if (c % 150 == 0) begin
            case ($urandom_range(2))
               0: pct = 70;
               1: pct = 30;
               default: pct = 6;
            endcase
         end
         rst_i = ($urandom_range(599) == 0);
         if (!d_req_i || g_d) begin
            d_req_i = ($urandom_range(2) == 0);
            d_we_i = $urandom_range(1);
            d_addr_i = $urandom;
            d_wdata_i = $urandom;
            d_be_i = 4'($urandom);
         end
         if (!if_req_i || g_if) begin
            if_req_i = ($urandom_range(1) == 0);
            if_addr_i = $urandom;
         end
         if_flush_i = ($urandom_range(7) == 0);
         mem_ready_i = ($urandom_range(99) < pct);
         mem_rdata_i = $urandom;
         step(0, vnone);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
